// File: rtl/fifo_word_packer.sv
// fifo_word_packer: pops bytes from a FIFO and packs LANES of them per valid/ready word, with flush of partial words.
module fifo_word_packer #(
   parameter int DATA_W = 8,
   parameter int LANES  = 4
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     fifo_empty,
   input  logic [DATA_W-1:0]        fifo_data,
   output logic                     fifo_rd_en,
   input  logic                     flush,
   output logic                     flush_busy,
   output logic [DATA_W*LANES-1:0]  word_data,
   output logic [LANES-1:0]         word_keep,
   output logic                     word_valid,
   input  logic                     word_ready
);
   localparam int FW = $clog2(LANES + 1);
   typedef enum logic [1:0] {FILL, FLUSH_WAIT, EMIT} state_t;
   state_t state, state_n;
   logic [FW-1:0] fill, fill_base;
   logic rd_pend, out_free, xfer;
   logic [DATA_W*LANES-1:0] pack;
   logic [LANES-1:0] keep_n;
   always_comb begin
      out_free   = !word_valid || word_ready;
      fifo_rd_en = rstn && !fifo_empty && state == FILL &&
                   ({1'b0, fill} + {{FW{1'b0}}, rd_pend}) < (FW+1)'(LANES);
      xfer       = out_free && (state == FILL ? fill == FW'(LANES) : state == EMIT);
      fill_base  = xfer ? '0 : fill;
      keep_n     = ~({LANES{1'b1}} << fill);
      state_n    = state;
      if (state == FILL && flush) state_n = FLUSH_WAIT;
      if (state == FLUSH_WAIT && !rd_pend) state_n = (fill == '0) ? FILL : EMIT;
      if (state == EMIT && out_free) state_n = FILL;
   end
   assign flush_busy = state != FILL;
   // pack is cleared on every transfer so lanes past fill read as zero in a flushed word
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state      <= FILL;
         fill       <= '0;
         rd_pend    <= 1'b0;
         pack       <= '0;
         word_data  <= '0;
         word_keep  <= '0;
         word_valid <= 1'b0;
      end else begin
         state   <= state_n;
         rd_pend <= fifo_rd_en;
         if (xfer) begin
            word_data  <= pack;
            word_keep  <= keep_n;
            word_valid <= 1'b1;
            pack       <= '0;
         end else if (word_ready) begin
            word_valid <= 1'b0;
         end
         fill <= rd_pend ? fill_base + FW'(1) : fill_base;
         if (rd_pend) pack[fill_base*DATA_W +: DATA_W] <= fifo_data;
      end
   end
endmodule

// File: tb/tb_fifo_word_packer.sv
// tb_fifo_word_packer: random and directed stimulus checked against a byte-stream model of the packer.
module tb_fifo_word_packer;
   localparam int DW = 8;
   localparam int L  = 4;
   localparam int WW = DW * L;
   logic clk = 1'b0, rstn = 1'b1, fifo_empty = 1'b1, flush = 1'b0, word_ready = 1'b0;
   logic [DW-1:0] fifo_data = '0;
   logic fifo_rd_en, flush_busy, word_valid;
   logic [WW-1:0] word_data;
   logic [L-1:0] word_keep;
   logic [DW-1:0] push_q[$], fq[$], acc[$];
   logic [WW-1:0] exp_d[$], got_d[$];
   logic [L-1:0] exp_k[$], got_k[$];
   int n_cmp = 0, n_bad = 0;
   logic stalled = 1'b0;
   logic [WW-1:0] pd;
   logic [L-1:0] pk;

   always #5 clk = ~clk;

   fifo_word_packer #(.DATA_W(DW), .LANES(L)) dut (
      .clk(clk), .rstn(rstn), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .fifo_rd_en(fifo_rd_en), .flush(flush), .flush_busy(flush_busy),
      .word_data(word_data), .word_keep(word_keep), .word_valid(word_valid),
      .word_ready(word_ready)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, req);
      end
   endtask

   // Model: the popped byte stream is cut into LANES-byte words; a flush cuts whatever is left.
   function automatic void emit();
      logic [WW-1:0] w = '0;
      logic [L-1:0] k = '0;
      for (int i = 0; i < acc.size(); i++) begin
         w[i*DW +: DW] = acc[i];
         k[i] = 1'b1;
      end
      exp_d.push_back(w);
      exp_k.push_back(k);
      acc.delete();
   endfunction

   always @(posedge clk) begin
      if (rstn) begin
         if (fifo_rd_en && fq.size() != 0) begin
            fifo_data <= fq[0];
            acc.push_back(fq.pop_front());
            if (acc.size() == L) emit();
         end
         if (flush && acc.size() != 0) emit();
      end
      while (push_q.size() != 0) fq.push_back(push_q.pop_front());
      fifo_empty <= (fq.size() == 0);
   end

   always @(negedge clk) begin
      if (rstn) begin
         chk("rd_en_while_empty", {63'd0, fifo_rd_en && fifo_empty}, 64'd0);
         if (stalled) begin
            chk("hold_valid", {63'd0, word_valid}, 64'd1);
            chk("hold_data", {32'd0, word_data}, {32'd0, pd});
            chk("hold_keep", {60'd0, word_keep}, {60'd0, pk});
         end
         if (word_valid && word_ready) begin
            if (exp_d.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL word_unexpected: got %0h expected no word", word_data);
            end else begin
               chk("word_data", {32'd0, word_data}, {32'd0, exp_d.pop_front()});
               chk("word_keep", {60'd0, word_keep}, {60'd0, exp_k.pop_front()});
            end
            got_d.push_back(word_data);
            got_k.push_back(word_keep);
         end
         stalled = word_valid && !word_ready;
         pd = word_data;
         pk = word_keep;
      end else begin
         stalled = 1'b0;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic push_range(input int first, input int n);
      for (int i = 0; i < n; i++) push_q.push_back(DW'(first + i));
   endtask

   task automatic wait_words(input int n, input int budget, input string nm);
      int t = 0;
      while (got_d.size() < n && t < budget) begin
         cyc(1);
         t++;
      end
      chk(nm, {63'd0, got_d.size() >= n}, 64'd1);
   endtask

   task automatic wait_idle(input int budget);
      int t = 0;
      while ((fq.size() != 0 || push_q.size() != 0 || exp_d.size() != 0 || flush_busy) && t < budget) begin
         cyc(1);
         t++;
      end
      chk("idle_timeout", {63'd0, t < budget}, 64'd1);
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      cyc(1);
      flush = 1'b0;
   endtask

   initial begin
      int base, bc;
      #1 rstn = 1'b0;
      cyc(2);
      chk("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
      chk("rst_valid", {63'd0, word_valid}, 64'd0);
      chk("rst_data", {32'd0, word_data}, 64'd0);
      chk("rst_keep", {60'd0, word_keep}, 64'd0);
      chk("rst_busy", {63'd0, flush_busy}, 64'd0);
      rstn = 1'b1;
      cyc(1);
      // full-rate streaming
      word_ready = 1'b1;
      push_range(8'h00, 32);
      wait_words(8, 200, "stream_timeout");
      chk("stream_w0", {32'd0, got_d[0]}, 64'h03020100);
      chk("stream_w7", {32'd0, got_d[7]}, 64'h1F1E1D1C);
      chk("stream_k0", {60'd0, got_k[0]}, 64'hF);
      wait_idle(100);
      // backpressure
      base = got_d.size();
      word_ready = 1'b0;
      push_range(8'h20, 32);
      cyc(30);
      chk("bp_valid", {63'd0, word_valid}, 64'd1);
      chk("bp_data", {32'd0, word_data}, 64'h23222120);
      chk("bp_rd_en_stopped", {63'd0, fifo_rd_en}, 64'd0);
      word_ready = 1'b1;
      wait_words(base + 8, 200, "bp_timeout");
      chk("bp_last", {32'd0, got_d[base+7]}, 64'h3F3E3D3C);
      wait_idle(100);
      // partial flush
      base = got_d.size();
      push_q.push_back(8'hA0);
      push_q.push_back(8'hA1);
      push_q.push_back(8'hA2);
      cyc(8);
      pulse_flush();
      chk("flush_busy_high", {63'd0, flush_busy}, 64'd1);
      wait_words(base + 1, 20, "flush_timeout");
      chk("flush_data", {32'd0, got_d[base]}, 64'h00A2A1A0);
      chk("flush_keep", {60'd0, got_k[base]}, 64'h7);
      cyc(1);
      chk("flush_busy_low", {63'd0, flush_busy}, 64'd0);
      // empty flush
      base = got_d.size();
      cyc(3);
      pulse_flush();
      bc = 1;
      repeat (4) begin
         if (flush_busy) bc++;
         cyc(1);
      end
      chk("empty_flush_busy_le2", {63'd0, bc <= 2}, 64'd1);
      chk("empty_flush_no_word", got_d.size(), base);
      chk("empty_flush_valid", {63'd0, word_valid}, 64'd0);
      // flush coinciding with a read
      base = got_d.size();
      push_q.push_back(8'hB0);
      cyc(6);
      push_q.push_back(8'hB1);
      cyc(1);
      chk("coincide_rd_en", {63'd0, fifo_rd_en}, 64'd1);
      pulse_flush();
      wait_words(base + 1, 20, "coincide_timeout");
      chk("coincide_data", {32'd0, got_d[base]}, 64'h0000B1B0);
      chk("coincide_keep", {60'd0, got_k[base]}, 64'h3);
      wait_idle(50);
      // reset mid-word
      word_ready = 1'b0;
      push_range(8'hC0, 6);
      cyc(20);
      chk("mid_valid", {63'd0, word_valid}, 64'd1);
      rstn = 1'b0;
      #1;
      chk("mid_rst_valid", {63'd0, word_valid}, 64'd0);
      chk("mid_rst_data", {32'd0, word_data}, 64'd0);
      chk("mid_rst_keep", {60'd0, word_keep}, 64'd0);
      chk("mid_rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
      acc.delete();
      exp_d.delete();
      exp_k.delete();
      cyc(2);
      rstn = 1'b1;
      word_ready = 1'b1;
      base = got_d.size();
      push_range(8'hD0, 4);
      wait_words(base + 1, 40, "post_rst_timeout");
      chk("post_rst_data", {32'd0, got_d[base]}, 64'hD3D2D1D0);
      wait_idle(50);
      // randomized traffic
      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(2) == 0 && fq.size() < 12) push_q.push_back(DW'($urandom));
         word_ready = ($urandom_range(3) != 0);
         flush = !flush_busy && ($urandom_range(24) == 0);
         cyc(1);
      end
      flush = 1'b0;
      word_ready = 1'b1;
      wait_idle(200);
      pulse_flush();
      wait_idle(50);
      chk("final_acc_empty", acc.size(), 0);
      chk("final_exp_empty", exp_d.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
